sc_upcount_strobe_gen: RTL and testbench
========================================

// Module: sc_upcount_strobe_gen
// PURPOSE
//  Upstream stage of the dual-channel up-counter. Produces the two active-low one-cycle
//  count-enable strobes that feed the counter's upcount_InLow / upcount_InLow_2 inputs:
//  ch0 = periodic game tick from a programmable prescaler, ch1 = debounced push-button press.
//  Channels are independent; both strobes are registered outputs.
// PARAMETERS
//  PRESCALER_DIV    50000000  tick period in clocks (>=1); 50 MHz -> 1 Hz
//  PRESCALER_WIDTH  26        prescaler counter width; must hold PRESCALER_DIV-1
//  DEBOUNCE_CYCLES  1000000   stable-level clocks required to accept press/release (>=1); 20 ms
//  DEBOUNCE_WIDTH   20        debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  SC_upCOUNTER_CLOCK_50      in   1   system clock, 50 MHz, rising edge
//  SC_upCOUNTER_RESET_InHigh  in   1   reset, asynchronous, active-high
//  STROBE_run_InHigh          in   1   1 = prescaler runs, 0 = pause (count holds)
//  STROBE_button_InLow        in   1   raw asynchronous push button, 0 = pressed
//  STROBE_tick_OutLow         out  1   periodic strobe, 0 for one cycle -> upcount_InLow
//  STROBE_press_OutLow        out  1   press strobe, 0 for one cycle -> upcount_InLow_2
//  STROBE_prescale_OutBUS     out  PRESCALER_WIDTH  current prescaler count (debug)
//  STROBE_btnState_OutBUS     out  2   button FSM state (debug)
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): tick=1, press=1, prescale=0, FSM=IDLE,
//   both synchronizer flops=1 (released), debounce count=0.
//  Prescaler: run=1 -> count==PRESCALER_DIV-1 ? 0 : count+1; run=0 -> count holds.
//   Tick register <= ~(run & count==PRESCALER_DIV-1): exactly one low cycle per
//   PRESCALER_DIV running cycles; pause never emits and resume continues from held count.
//   PRESCALER_DIV=1 -> tick low every cycle while run=1. Counter wraps, never saturates.
//  Button sync: 2-flop synchronizer -> b_s; raw level sampled at edge k is on b_s after edge k+1.
//  Button FSM (count cleared on every state change):
//   IDLE        (00): b_s=0 -> PRESS_WAIT.
//   PRESS_WAIT  (01): b_s=1 -> IDLE (bounce, no strobe); count==DEBOUNCE_CYCLES-1 -> PRESSED
//                     and press register <= 0 for that one cycle; else count+1.
//   PRESSED     (10): b_s=1 -> RELEASE_WAIT; held button never repeats the strobe.
//   RELEASE_WAIT(11): b_s=0 -> PRESSED (bounce, no strobe); count==DEBOUNCE_CYCLES-1 -> IDLE.
//  Press latency: raw low stable from sampling edge k -> press low during cycle after
//   edge k+DEBOUNCE_CYCLES+2, exactly one cycle, then 1.
//  Simultaneous: tick and press may be low in the same cycle; no arbitration, no interaction.
//  Outputs glitch-free: both strobes driven directly from flops.
// STRUCTURE
//  Package sc_strobe_pkg: localparams for FSM encodings (IDLE=2'b00, PRESS_WAIT=2'b01,
//   PRESSED=2'b10, RELEASE_WAIT=2'b11).
//  Sub-module sc_button_debouncer: synchronizer + FSM + debounce counter + press register.
//  Top: prescaler and tick register inline, one sc_button_debouncer instance.
// TESTING  (bench params PRESCALER_DIV=5, DEBOUNCE_CYCLES=4)
//  1 Reset: assert reset between clock edges mid-count -> tick=1, press=1, prescale=0,
//    btnState=00 immediately, before next edge.
//  2 Tick: run=1 for 20 cycles -> prescale 0,1,2,3,4,0..; tick low exactly 4 times, spaced 5 cycles.
//  3 Pause: drop run at prescale=3 for 7 cycles -> prescale stays 3, tick stays 1; raise run ->
//    tick low after 2 more cycles.
//  4 Clean press: button 0 from edge 0, held 30 cycles -> press low only in cycle after edge 6,
//    btnState 01 then 10, no repeat; release -> 11, then 00 four cycles later, no strobe.
//  5 Bounce: button 0 for 2 cycles, 1 for 1, then 0 held -> first episode returns 01->00, no
//    strobe; one strobe 6 edges after final stable low.
//  6 Coincidence: align press strobe with tick strobe -> both low in same cycle, each one cycle,
//    prescale sequence unaffected.

Source files
------------

// File: rtl/sc_strobe_pkg.sv
// ---------------------------------------------------------------------------
// sc_strobe_pkg
// Shared constants for the up-counter strobe generator.
// Contents:
//   STATE_W          width of the button FSM state register
//   ST_IDLE ..       button FSM state encodings; the encodings are visible
//                    on the debug bus, so they must not change
// ---------------------------------------------------------------------------
package sc_strobe_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ST_IDLE         = 2'b00;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'b01;
    localparam logic [1:0] ST_PRESSED      = 2'b10;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'b11;

endpackage : sc_strobe_pkg

// File: rtl/sc_button_debouncer.sv
// ---------------------------------------------------------------------------
// sc_button_debouncer
// Synchronises a raw active-low push button, debounces press and release,
// and emits a single active-low one-cycle strobe per accepted press.
// Ports:
//   SC_upCOUNTER_CLOCK_50      in   system clock, rising edge
//   SC_upCOUNTER_RESET_InHigh  in   asynchronous active-high reset
//   button_i                   in   raw asynchronous button, 0 = pressed
//   press_o                    out  registered press strobe, 0 for one cycle
//   state_o                    out  FSM state (debug)
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | button accepted as released
// PRESS_WAIT   | synced level low, counting stable-low clocks
// PRESSED      | button accepted as pressed, strobe already issued
// RELEASE_WAIT | synced level high, counting stable-high clocks
// ---------------------------------------------------------------------------
module sc_button_debouncer
    import sc_strobe_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DEBOUNCE_WIDTH  = 20
) (
    input  logic               SC_upCOUNTER_CLOCK_50,
    input  logic               SC_upCOUNTER_RESET_InHigh,
    input  logic               button_i,
    output logic               press_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [DEBOUNCE_WIDTH-1:0] DB_TC = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                      sync1_q;
    logic                      sync2_q;
    logic [STATE_W-1:0]        state_q, state_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      press_q, press_d;

    // Synchronizer resets to the released level so no false press follows reset.
    always_ff @(posedge SC_upCOUNTER_CLOCK_50 or posedge SC_upCOUNTER_RESET_InHigh) begin
        if (SC_upCOUNTER_RESET_InHigh) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
        end
    end

    // A bounce back to the accepted level always wins over terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = ST_PRESS_WAIT;
            end
            ST_PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_TC) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
                end
            end
            ST_PRESSED: begin
                cnt_d = '0;
                if (sync2_q) state_d = ST_RELEASE_WAIT;
            end
            ST_RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_TC) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DEBOUNCE_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge SC_upCOUNTER_CLOCK_50 or posedge SC_upCOUNTER_RESET_InHigh) begin
        if (SC_upCOUNTER_RESET_InHigh) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
    assign state_o = state_q;

endmodule : sc_button_debouncer

// File: rtl/sc_upcount_strobe_gen.sv
// ---------------------------------------------------------------------------
// sc_upcount_strobe_gen
// Generates the two active-low count-enable strobes for the dual-channel
// up-counter: ch0 is a periodic tick from a pausable prescaler, ch1 is a
// debounced push-button press. The channels do not interact.
// Ports:
//   SC_upCOUNTER_CLOCK_50      in   system clock, 50 MHz
//   SC_upCOUNTER_RESET_InHigh  in   asynchronous active-high reset
//   STROBE_run_InHigh          in   1 = prescaler runs, 0 = count holds
//   STROBE_button_InLow        in   raw button, 0 = pressed
//   STROBE_tick_OutLow         out  periodic strobe, 0 for one cycle
//   STROBE_press_OutLow        out  press strobe, 0 for one cycle
//   STROBE_prescale_OutBUS     out  prescaler count (debug)
//   STROBE_btnState_OutBUS     out  button FSM state (debug)
// ---------------------------------------------------------------------------
module sc_upcount_strobe_gen
    import sc_strobe_pkg::*;
#(
    parameter int unsigned PRESCALER_DIV   = 50000000,
    parameter int unsigned PRESCALER_WIDTH = 26,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DEBOUNCE_WIDTH  = 20
) (
    input  logic                       SC_upCOUNTER_CLOCK_50,
    input  logic                       SC_upCOUNTER_RESET_InHigh,
    input  logic                       STROBE_run_InHigh,
    input  logic                       STROBE_button_InLow,
    output logic                       STROBE_tick_OutLow,
    output logic                       STROBE_press_OutLow,
    output logic [PRESCALER_WIDTH-1:0] STROBE_prescale_OutBUS,
    output logic [STATE_W-1:0]         STROBE_btnState_OutBUS
);

    localparam logic [PRESCALER_WIDTH-1:0] PS_TC = PRESCALER_WIDTH'(PRESCALER_DIV - 1);

    logic [PRESCALER_WIDTH-1:0] prescale_q, prescale_d;
    logic                       tick_q, tick_d;
    logic                       at_tc;

    assign at_tc = (prescale_q == PS_TC);

    // Paused cycles hold the count and never emit, so resume continues the period.
    always_comb begin
        prescale_d = prescale_q;
        if (STROBE_run_InHigh) begin
            prescale_d = at_tc ? '0 : prescale_q + PRESCALER_WIDTH'(1);
        end
        tick_d = ~(STROBE_run_InHigh & at_tc);
    end

    always_ff @(posedge SC_upCOUNTER_CLOCK_50 or posedge SC_upCOUNTER_RESET_InHigh) begin
        if (SC_upCOUNTER_RESET_InHigh) begin
            prescale_q <= '0;
            tick_q     <= 1'b1;
        end else begin
            prescale_q <= prescale_d;
            tick_q     <= tick_d;
        end
    end

    sc_button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_WIDTH  (DEBOUNCE_WIDTH)
    ) u_debouncer (
        .SC_upCOUNTER_CLOCK_50     (SC_upCOUNTER_CLOCK_50),
        .SC_upCOUNTER_RESET_InHigh (SC_upCOUNTER_RESET_InHigh),
        .button_i                  (STROBE_button_InLow),
        .press_o                   (STROBE_press_OutLow),
        .state_o                   (STROBE_btnState_OutBUS)
    );

    assign STROBE_tick_OutLow     = tick_q;
    assign STROBE_prescale_OutBUS = prescale_q;

endmodule : sc_upcount_strobe_gen

// File: tb/tb_sc_upcount_strobe_gen.sv
module tb_sc_upcount_strobe_gen;

    localparam int DIV = 5;
    localparam int PW  = 3;
    localparam int DC  = 4;
    localparam int DW  = 2;

    logic          clk;
    logic          rst;
    logic          run;
    logic          btn;
    logic          tick;
    logic          press;
    logic [PW-1:0] pre;
    logic [1:0]    st;

    sc_upcount_strobe_gen #(
        .PRESCALER_DIV   (DIV),
        .PRESCALER_WIDTH (PW),
        .DEBOUNCE_CYCLES (DC),
        .DEBOUNCE_WIDTH  (DW)
    ) dut (
        .SC_upCOUNTER_CLOCK_50     (clk),
        .SC_upCOUNTER_RESET_InHigh (rst),
        .STROBE_run_InHigh         (run),
        .STROBE_button_InLow       (btn),
        .STROBE_tick_OutLow        (tick),
        .STROBE_press_OutLow       (press),
        .STROBE_prescale_OutBUS    (pre),
        .STROBE_btnState_OutBUS    (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural reference: the tick fires on every DIV-th running cycle;
    // the button level is seen two edges late and is accepted once it has
    // differed from the accepted level on DC+1 consecutive edges.
    int m_cnt;
    int m_tick;
    int m_press;
    int m_acc;
    int m_len;
    int m_pipe[2];

    function automatic void model_reset();
        m_cnt = 0; m_tick = 1; m_press = 1; m_acc = 1; m_len = 0;
        m_pipe[0] = 1; m_pipe[1] = 1;
    endfunction

    function automatic void model_edge(input int r, input int b);
        int seen;
        seen = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = b;
        m_tick = (r != 0 && m_cnt == DIV - 1) ? 0 : 1;
        if (r != 0) m_cnt = (m_cnt + 1) % DIV;
        m_press = 1;
        if (seen != m_acc) begin
            m_len++;
            if (m_len == DC + 1) begin
                m_acc = seen;
                m_len = 0;
                if (seen == 0) m_press = 0;
            end
        end else begin
            m_len = 0;
        end
    endfunction

    function automatic int model_state();
        if (m_acc == 1) return (m_len > 0) ? 1 : 0;
        return (m_len > 0) ? 3 : 2;
    endfunction

    task automatic model_check();
        chk("model_tick", int'(tick), m_tick);
        chk("model_press", int'(press), m_press);
        chk("model_prescale", int'(pre), m_cnt);
        chk("model_state", int'(st), model_state());
    endtask

    // Inputs change at the negedge; outputs are sampled at the next negedge.
    task automatic step(input logic r, input logic b);
        run = r;
        btn = b;
        @(posedge clk);
        model_edge(int'(r), int'(b));
        @(negedge clk);
        model_check();
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        model_edge(int'(run), int'(btn));
        #3 rst = 1'b1;
        #1;
        chk("rst_tick", int'(tick), 1);
        chk("rst_press", int'(press), 1);
        chk("rst_prescale", int'(pre), 0);
        chk("rst_state", int'(st), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic run;
        logic btn;
        int   tick;
        int   press;
        int   pre;
        int   st;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   press_at;
        int   press_cnt;
        int   hold;
        logic rb;
        logic bounce[20];

        //         run   btn   tick press pre st
        vecs[0]  = '{1'b1, 1'b0, 1, 1, 1, 0};
        vecs[1]  = '{1'b1, 1'b0, 1, 1, 2, 0};
        vecs[2]  = '{1'b1, 1'b0, 1, 1, 3, 1};
        vecs[3]  = '{1'b1, 1'b0, 1, 1, 4, 1};
        vecs[4]  = '{1'b1, 1'b0, 0, 1, 0, 1};
        vecs[5]  = '{1'b1, 1'b0, 1, 1, 1, 1};
        vecs[6]  = '{1'b1, 1'b0, 1, 0, 2, 2};
        vecs[7]  = '{1'b1, 1'b0, 1, 1, 3, 2};
        vecs[8]  = '{1'b1, 1'b0, 1, 1, 4, 2};
        vecs[9]  = '{1'b1, 1'b0, 0, 1, 0, 2};
        vecs[10] = '{1'b1, 1'b1, 1, 1, 1, 2};
        vecs[11] = '{1'b1, 1'b1, 1, 1, 2, 2};
        vecs[12] = '{1'b1, 1'b1, 1, 1, 3, 3};
        vecs[13] = '{1'b1, 1'b1, 1, 1, 4, 3};
        vecs[14] = '{1'b1, 1'b1, 0, 1, 0, 3};
        vecs[15] = '{1'b1, 1'b1, 1, 1, 1, 3};
        vecs[16] = '{1'b1, 1'b1, 1, 1, 2, 0};
        vecs[17] = '{1'b1, 1'b1, 1, 1, 3, 0};

        rst = 1'b1; run = 1'b0; btn = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Table: running tick plus a clean press and release.
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].run, vecs[i].btn);
            chk($sformatf("vec%0d_tick", i), int'(tick), vecs[i].tick);
            chk($sformatf("vec%0d_press", i), int'(press), vecs[i].press);
            chk($sformatf("vec%0d_prescale", i), int'(pre), vecs[i].pre);
            chk($sformatf("vec%0d_state", i), int'(st), vecs[i].st);
        end

        // Reset while the prescaler is mid-count.
        mid_reset();

        // Pause at prescale 3, hold for 7 cycles, resume.
        repeat (3) step(1'b1, 1'b1);
        chk("pause_start", int'(pre), 3);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1);
            chk("pause_hold", int'(pre), 3);
            chk("pause_tick", int'(tick), 1);
        end
        step(1'b1, 1'b1);
        chk("resume1_tick", int'(tick), 1);
        chk("resume1_prescale", int'(pre), 4);
        step(1'b1, 1'b1);
        chk("resume2_tick", int'(tick), 0);
        chk("resume2_prescale", int'(pre), 0);

        // Bounce: 0,0,1 then held low; one strobe after edge 9.
        mid_reset();
        for (int i = 0; i < 20; i++) bounce[i] = (i == 2) ? 1'b1 : 1'b0;
        press_at = -1;
        press_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, bounce[i]);
            if (i == 3) chk("bounce_wait_state", int'(st), 1);
            if (i == 4) chk("bounce_back_idle", int'(st), 0);
            if (press == 1'b0) begin
                press_cnt++;
                press_at = i;
            end
        end
        chk("bounce_press_count", press_cnt, 1);
        chk("bounce_press_edge", press_at, 9);

        // Coincidence: prescale starts at 3 so both strobes land after edge 6.
        mid_reset();
        repeat (3) step(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (i == 6) begin
                chk("coinc_tick", int'(tick), 0);
                chk("coinc_press", int'(press), 0);
                chk("coinc_prescale", int'(pre), 0);
            end
            if (i == 7) begin
                chk("coinc_tick_after", int'(tick), 1);
                chk("coinc_press_after", int'(press), 1);
            end
        end

        // Random run/button activity with occasional mid-cycle resets.
        hold = 0;
        rb = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                rb = $urandom_range(0, 1) != 0;
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 99) == 0) begin
                run = $urandom_range(0, 3) != 0;
                btn = rb;
                mid_reset();
            end else begin
                step($urandom_range(0, 3) != 0, rb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sc_upcount_strobe_gen
